// File: rtl/sata_rx_dword_aligner_if.sv
// Bus between the transceiver RX parallel interface, the aligner and the link layer.
interface sata_rx_dword_aligner_if;
  logic [31:0] rx_data;
  logic [3:0]  rx_datak;
  logic [3:0]  rx_disperr;
  logic [3:0]  rx_errdetect;
  logic [3:0]  rx_syncstatus;
  logic        rx_wa_patternalign;
  logic [31:0] out_data;
  logic [3:0]  out_datak;
  logic        out_valid;
  logic        out_err;
  logic        align_det;
  logic        aligned;

  modport master (
    output rx_data, rx_datak, rx_disperr, rx_errdetect, rx_syncstatus,
    input  rx_wa_patternalign, out_data, out_datak, out_valid, out_err, align_det, aligned
  );
  modport slave (
    input  rx_data, rx_datak, rx_disperr, rx_errdetect, rx_syncstatus,
    output rx_wa_patternalign, out_data, out_datak, out_valid, out_err, align_det, aligned
  );
endinterface

// File: rtl/sata_rx_dword_aligner.sv
// Locates the byte rotation of the SATA ALIGN primitive in the rx_clkout stream,
// qualifies lock and re-emits dword-aligned data with K/error flags.

module sata_rx_align_win #(
  parameter int OFF = 0
) (
  input  logic [55:0] stream_data,
  input  logic [6:0]  stream_k,
  input  logic [6:0]  stream_err,
  output logic [31:0] win_data,
  output logic [3:0]  win_k,
  output logic        win_err,
  output logic        win_align
);
  assign win_data  = stream_data[OFF*8 +: 32];
  assign win_k     = stream_k[OFF +: 4];
  assign win_err   = |stream_err[OFF +: 4];
  assign win_align = (win_data == 32'h7B4A4ABC) && (win_k == 4'b0001) && !win_err;
endmodule

module sata_rx_dword_aligner #(
  parameter int ALIGN_LOCK_CNT = 3,
  parameter int ERR_LOSS_CNT   = 4,
  parameter int HUNT_TIMEOUT   = 1024
) (
  input logic                    clk,
  input logic                    reset_n,
  sata_rx_dword_aligner_if.slave bus
);
  localparam int NUM_OFF = 4;
  localparam logic [3:0]  LOCK_M1 = 4'(ALIGN_LOCK_CNT - 1);
  localparam logic [3:0]  LOSS_M1 = 4'(ERR_LOSS_CNT - 1);
  localparam logic [15:0] TMO_M1  = 16'(HUNT_TIMEOUT - 1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t      state;
  logic [31:0] prev_data;
  logic [3:0]  prev_k, prev_err;
  logic [1:0]  cand_off, act_off;
  logic [3:0]  cnt, err_cnt;
  logic [15:0] hunt_tmr;

  // Byte 7 of the 8-byte window is never part of any candidate.
  logic [55:0] stream_data;
  logic [6:0]  stream_k, stream_err;
  assign stream_data = {bus.rx_data[23:0], prev_data};
  assign stream_k    = {bus.rx_datak[2:0], prev_k};
  assign stream_err  = {bus.rx_disperr[2:0] | bus.rx_errdetect[2:0], prev_err};

  logic [NUM_OFF-1:0][31:0] win_data;
  logic [NUM_OFF-1:0][3:0]  win_k;
  logic [NUM_OFF-1:0]       win_err, win_align;

  for (genvar g = 0; g < NUM_OFF; g++) begin : g_win
    sata_rx_align_win #(.OFF(g)) u_win (
      .stream_data (stream_data),
      .stream_k    (stream_k),
      .stream_err  (stream_err),
      .win_data    (win_data[g]),
      .win_k       (win_k[g]),
      .win_err     (win_err[g]),
      .win_align   (win_align[g])
    );
  end

  logic [1:0] first_off;
  logic       any_match;
  always_comb begin
    first_off = '0;
    any_match = 1'b0;
    for (int i = NUM_OFF - 1; i >= 0; i--) begin
      if (win_align[i]) begin
        first_off = 2'(i);
        any_match = 1'b1;
      end
    end
  end

  logic sync_lost, loss_hit;
  assign sync_lost = (bus.rx_syncstatus == 4'b0000);
  assign loss_hit  = win_err[act_off] && (err_cnt >= LOSS_M1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                  <= HUNT;
      prev_data              <= '0;
      prev_k                 <= '0;
      prev_err               <= '0;
      cand_off               <= '0;
      act_off                <= '0;
      cnt                    <= '0;
      err_cnt                <= '0;
      hunt_tmr               <= '0;
      bus.rx_wa_patternalign <= 1'b0;
      bus.out_data           <= '0;
      bus.out_datak          <= '0;
      bus.out_valid          <= 1'b0;
      bus.out_err            <= 1'b0;
      bus.align_det          <= 1'b0;
      bus.aligned            <= 1'b0;
    end else begin
      prev_data              <= bus.rx_data;
      prev_k                 <= bus.rx_datak;
      prev_err               <= bus.rx_disperr | bus.rx_errdetect;
      bus.out_data           <= win_data[act_off];
      bus.out_datak          <= win_k[act_off];
      bus.out_err            <= win_err[act_off];
      bus.align_det          <= (state == LOCKED) && win_align[act_off];
      bus.rx_wa_patternalign <= 1'b0;
      // Sync loss overrides everything; pulse only if the error limit coincides.
      if (sync_lost) begin
        state                  <= HUNT;
        cnt                    <= '0;
        err_cnt                <= '0;
        hunt_tmr               <= '0;
        bus.aligned            <= 1'b0;
        bus.out_valid          <= 1'b0;
        bus.rx_wa_patternalign <= (state == LOCKED) && loss_hit;
      end else begin
        case (state)
          HUNT: begin
            if (any_match) begin
              cand_off <= first_off;
              cnt      <= 4'd1;
              hunt_tmr <= '0;
              if (ALIGN_LOCK_CNT == 1) begin
                state         <= LOCKED;
                act_off       <= first_off;
                err_cnt       <= '0;
                bus.aligned   <= 1'b1;
                bus.out_valid <= 1'b1;
              end else begin
                state <= VERIFY;
              end
            end else if (hunt_tmr >= TMO_M1) begin
              bus.rx_wa_patternalign <= 1'b1;
              hunt_tmr               <= '0;
            end else begin
              hunt_tmr <= hunt_tmr + 16'd1;
            end
          end
          VERIFY: begin
            if (win_align[cand_off]) begin
              if (cnt != 4'hF) cnt <= cnt + 4'd1;
              if (cnt >= LOCK_M1) begin
                state         <= LOCKED;
                act_off       <= cand_off;
                err_cnt       <= '0;
                bus.aligned   <= 1'b1;
                bus.out_valid <= 1'b1;
              end
            end else if (any_match) begin
              cand_off <= first_off;
              cnt      <= 4'd1;
            end else if (win_err[cand_off]) begin
              state    <= HUNT;
              cnt      <= '0;
              hunt_tmr <= '0;
            end
          end
          LOCKED: begin
            if (win_err[act_off]) begin
              if (loss_hit) begin
                state                  <= HUNT;
                cnt                    <= '0;
                err_cnt                <= '0;
                hunt_tmr               <= '0;
                bus.aligned            <= 1'b0;
                bus.out_valid          <= 1'b0;
                bus.rx_wa_patternalign <= 1'b1;
              end else if (err_cnt != 4'hF) begin
                err_cnt <= err_cnt + 4'd1;
              end
            end else begin
              err_cnt <= '0;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sata_rx_dword_aligner.sv
// Directed + randomized bench for sata_rx_dword_aligner against a byte-stream reference model.
module tb_sata_rx_dword_aligner;
  localparam int LOCK = 3, LOSS = 4, TMO = 16;
  localparam int M_HUNT = 0, M_VERIFY = 1, M_LOCKED = 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  sata_rx_dword_aligner_if bus();

  sata_rx_dword_aligner #(.ALIGN_LOCK_CNT(LOCK), .ERR_LOSS_CNT(LOSS), .HUNT_TIMEOUT(TMO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0, n_fail = 0;

  // Reference model state: the last dword as a list of bytes, plus link-level status.
  logic [7:0] m_pb[4];
  bit         m_pk[4], m_pe[4];
  int m_mode, m_act, m_cand, m_cnt, m_errc, m_tmr;
  logic [31:0] e_data, e_k, e_valid, e_err, e_det, e_aligned, e_pulse;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_pb[i] = 8'h00; m_pk[i] = 0; m_pe[i] = 0; end
    m_mode = M_HUNT; m_act = 0; m_cand = 0; m_cnt = 0; m_errc = 0; m_tmr = 0;
    e_data = 0; e_k = 0; e_valid = 0; e_err = 0; e_det = 0; e_aligned = 0; e_pulse = 0;
  endtask

  task automatic model(input logic [31:0] d, input logic [3:0] k, input logic [3:0] e, input logic [3:0] ss);
    logic [7:0] s[8];
    bit ks[8], es[8], al[4], we[4], pulse;
    int first;
    for (int i = 0; i < 4; i++) begin
      s[i] = m_pb[i]; ks[i] = m_pk[i]; es[i] = m_pe[i];
      s[i+4] = d[8*i +: 8]; ks[i+4] = k[i]; es[i+4] = e[i];
    end
    first = -1;
    for (int o = 3; o >= 0; o--) begin
      we[o] = es[o] | es[o+1] | es[o+2] | es[o+3];
      al[o] = (s[o] == 8'hBC) && (s[o+1] == 8'h4A) && (s[o+2] == 8'h4A) && (s[o+3] == 8'h7B)
              && ks[o] && !ks[o+1] && !ks[o+2] && !ks[o+3] && !we[o];
      if (al[o]) first = o;
    end
    e_data = {s[m_act+3], s[m_act+2], s[m_act+1], s[m_act]};
    e_k    = {28'd0, ks[m_act+3], ks[m_act+2], ks[m_act+1], ks[m_act]};
    e_err  = 32'(we[m_act]);
    e_det  = 32'(m_mode == M_LOCKED && al[m_act]);
    pulse  = 0;
    if (ss == 4'b0000) begin
      pulse = (m_mode == M_LOCKED) && we[m_act] && (m_errc + 1 >= LOSS);
      m_mode = M_HUNT; m_cnt = 0; m_errc = 0; m_tmr = 0;
    end else if (m_mode == M_HUNT) begin
      if (first >= 0) begin
        m_cand = first; m_cnt = 1; m_tmr = 0; m_mode = M_VERIFY;
      end else if (m_tmr == TMO - 1) begin
        pulse = 1; m_tmr = 0;
      end else m_tmr++;
    end else if (m_mode == M_VERIFY) begin
      if (al[m_cand]) begin
        m_cnt++;
        if (m_cnt >= LOCK) begin m_mode = M_LOCKED; m_act = m_cand; m_errc = 0; end
      end else if (first >= 0) begin
        m_cand = first; m_cnt = 1;
      end else if (we[m_cand]) begin
        m_mode = M_HUNT; m_cnt = 0; m_tmr = 0;
      end
    end else begin
      if (we[m_act]) begin
        if (m_errc + 1 >= LOSS) begin
          pulse = 1; m_mode = M_HUNT; m_errc = 0; m_cnt = 0; m_tmr = 0;
        end else m_errc++;
      end else m_errc = 0;
    end
    e_pulse = 32'(pulse);
    e_valid = 32'(m_mode == M_LOCKED);
    e_aligned = e_valid;
    for (int i = 0; i < 4; i++) begin m_pb[i] = d[8*i +: 8]; m_pk[i] = k[i]; m_pe[i] = e[i]; end
  endtask

  task automatic check_all();
    chk("out_data", bus.out_data, e_data);
    chk("out_datak", 32'(bus.out_datak), e_k);
    chk("out_valid", 32'(bus.out_valid), e_valid);
    chk("out_err", 32'(bus.out_err), e_err);
    chk("align_det", 32'(bus.align_det), e_det);
    chk("aligned", 32'(bus.aligned), e_aligned);
    chk("realign", 32'(bus.rx_wa_patternalign), e_pulse);
  endtask

  // One dword per call: called at posedge+1, returns at the next posedge+1.
  task automatic cyc(input logic [31:0] d, input logic [3:0] k, input logic [3:0] de,
                     input logic [3:0] ee, input logic [3:0] ss);
    bus.rx_data = d; bus.rx_datak = k; bus.rx_disperr = de;
    bus.rx_errdetect = ee; bus.rx_syncstatus = ss;
    @(posedge clk);
    model(d, k, de | ee, ss);
    #1;
    check_all();
  endtask

  task automatic dw(input logic [31:0] d, input logic [3:0] k);
    cyc(d, k, 4'h0, 4'h0, 4'hF);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_aligned", 32'(bus.aligned), 32'd0);
    chk("rst_data", bus.out_data, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  logic [8:0] q[$];
  task automatic refill();
    int r;
    logic [7:0] b;
    r = $urandom_range(0, 9);
    if (r < 3) begin
      q.push_back(9'h1BC); q.push_back(9'h04A); q.push_back(9'h04A); q.push_back(9'h07B);
    end else begin
      for (int i = 0; i < ((r == 3) ? int'($urandom_range(1, 3)) : 4); i++) begin
        b = 8'($urandom);
        q.push_back({1'b0, b});
      end
    end
  endtask

  int npulse;
  localparam logic [31:0] ALIGN_W = 32'h7B4A4ABC;

  initial begin
    bus.rx_data = '0; bus.rx_datak = '0; bus.rx_disperr = '0;
    bus.rx_errdetect = '0; bus.rx_syncstatus = 4'hF;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_realign", 32'(bus.rx_wa_patternalign), 32'd0);
    reset_n = 1'b1;

    // Offset 0 lock
    npulse = 0;
    for (int i = 0; i < 3; i++) begin dw(ALIGN_W, 4'b0001); npulse += int'(bus.rx_wa_patternalign); end
    dw(32'h0, 4'h0);
    chk("lock0_aligned", 32'(bus.aligned), 32'd1);
    dw(ALIGN_W, 4'b0001);
    dw(32'h12345678, 4'h0);
    chk("lock0_data", bus.out_data, ALIGN_W);
    chk("lock0_det", 32'(bus.align_det), 32'd1);
    npulse += int'(bus.rx_wa_patternalign);
    chk("lock0_nopulse", 32'(npulse), 32'd0);

    // Offset 2 lock, then data bytes 11,22,33,44
    do_reset();
    for (int i = 0; i < 3; i++) begin
      dw(32'h4ABC0000, 4'b0100);
      dw((i == 2) ? 32'h22117B4A : 32'h00007B4A, 4'b0000);
    end
    dw(32'h00004433, 4'h0);
    chk("lock2_aligned", 32'(bus.aligned), 32'd1);
    chk("lock2_data", bus.out_data, 32'h44332211);
    dw(32'h0, 4'h0);

    // Lock loss after 4 erroneous dwords
    for (int i = 0; i < 4; i++) cyc(32'h0, 4'h0, 4'h0, 4'hF, 4'hF);
    chk("loss_aligned", 32'(bus.aligned), 32'd0);
    chk("loss_pulse", 32'(bus.rx_wa_patternalign), 32'd1);
    dw(32'h0, 4'h0);
    chk("loss_pulse_end", 32'(bus.rx_wa_patternalign), 32'd0);

    // Relock, then 3 errors / clean / 3 errors: lock must hold
    for (int i = 0; i < 3; i++) dw(ALIGN_W, 4'b0001);
    dw(32'h0, 4'h0);
    chk("relock", 32'(bus.aligned), 32'd1);
    for (int i = 0; i < 9; i++) cyc(32'h0, 4'h0, 4'h0, (i == 3 || i >= 7) ? 4'h0 : 4'h2, 4'hF);
    chk("err_clear_aligned", 32'(bus.aligned), 32'd1);

    // Hunt timeout
    do_reset();
    npulse = 0;
    for (int i = 0; i < 32; i++) begin dw(32'($urandom), 4'h0); npulse += int'(bus.rx_wa_patternalign); end
    chk("tmo_pulses", 32'(npulse), 32'd2);
    for (int i = 0; i < 14; i++) dw(32'($urandom), 4'h0);
    dw(ALIGN_W, 4'b0001);
    dw(32'h0, 4'h0);
    chk("tmo_suppressed", 32'(bus.rx_wa_patternalign), 32'd0);

    // VERIFY restart: offset 1 then three at offset 3
    do_reset();
    dw(32'h4A4ABC00, 4'b0010);
    dw(32'h0000007B, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      dw(32'hBC000000, 4'b1000);
      if (i == 2) chk("restart_prelock", 32'(bus.aligned), 32'd0);
      dw(32'h007B4A4A, 4'b0000);
    end
    chk("restart_lock3", 32'(bus.aligned), 32'd1);
    dw(32'h0, 4'h0);

    // Sync loss while locked
    cyc(32'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    chk("sync_aligned", 32'(bus.aligned), 32'd0);
    chk("sync_nopulse", 32'(bus.rx_wa_patternalign), 32'd0);

    // Reset mid-VERIFY
    dw(32'hBC000000, 4'b1000);
    dw(32'h007B4A4A, 4'b0000);
    dw(32'hA5A5A5A5, 4'h0);
    do_reset();

    // Randomized stream
    for (int n = 0; n < 700; n++) begin
      logic [31:0] d;
      logic [3:0]  k, de, ee, ss;
      logic [8:0]  w;
      while (q.size() < 4) refill();
      for (int i = 0; i < 4; i++) begin
        w = q.pop_front();
        d[8*i +: 8] = w[7:0];
        k[i] = w[8];
      end
      de = ($urandom_range(0, 31) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      ee = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      ss = ($urandom_range(0, 99) == 0) ? 4'h0 : (($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'hF);
      cyc(d, k, de, ee, ss);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
